// File: rtl/point_plotter_pkg.sv
// Shared types and default widths for the point plotter.
// Holds the FSM state encoding and coordinate/colour defaults.
package point_plotter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_X_WIDTH     = 8;
  localparam int DEF_Y_WIDTH     = 7;
  localparam int DEF_COLOR_DEPTH = 1;

endpackage

// File: rtl/point_plotter.sv
// Scans a snapshot of point slots and emits one pixel per valid slot.
// Ports: clock/resetn, start/erase, per-slot valid/xs/ys/colors,
// plot_ready handshake, registered x/y/color/plot, busy, done.
module point_plotter
  import point_plotter_pkg::*;
#(
  parameter int NUM_POINTS  = 8,
  parameter int X_WIDTH     = DEF_X_WIDTH,
  parameter int Y_WIDTH     = DEF_Y_WIDTH,
  parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
  parameter logic [3*COLOR_DEPTH-1:0] BG_COLOR = '0
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic                                start,
  input  logic                                erase,
  input  logic [NUM_POINTS-1:0]               point_valid,
  input  logic [NUM_POINTS*X_WIDTH-1:0]       xs,
  input  logic [NUM_POINTS*Y_WIDTH-1:0]       ys,
  input  logic [NUM_POINTS*3*COLOR_DEPTH-1:0] colors,
  input  logic                                plot_ready,
  output logic [X_WIDTH-1:0]                  x,
  output logic [Y_WIDTH-1:0]                  y,
  output logic [3*COLOR_DEPTH-1:0]            color,
  output logic                                plot,
  output logic                                busy,
  output logic                                done
);

  localparam int CW = 3 * COLOR_DEPTH;
  localparam int IW =
    (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_POINTS - 1);

  state_t                         state;
  logic [IW-1:0]                  idx;
  logic [NUM_POINTS-1:0]          valid_snap;
  logic [NUM_POINTS*X_WIDTH-1:0]  xs_snap;
  logic [NUM_POINTS*Y_WIDTH-1:0]  ys_snap;
  logic [NUM_POINTS*CW-1:0]       colors_snap;
  logic                           erase_snap;

  logic [IW-1:0] nidx;
  logic          adv;

  // nidx is only consumed when idx is not LAST, so no wrap is used.
  assign nidx = idx + IW'(1);
  // Invalid slots drop after one cycle; valid ones wait for ready.
  assign adv  = (state == EMIT) &&
                (!valid_snap[idx] || plot_ready);
  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      idx         <= '0;
      valid_snap  <= '0;
      xs_snap     <= '0;
      ys_snap     <= '0;
      colors_snap <= '0;
      erase_snap  <= 1'b0;
      x           <= '0;
      y           <= '0;
      color       <= '0;
      plot        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            valid_snap  <= point_valid;
            xs_snap     <= xs;
            ys_snap     <= ys;
            colors_snap <= colors;
            erase_snap  <= erase;
            idx         <= '0;
            state       <= EMIT;
            // Slot 0 goes out on the start edge itself.
            plot        <= point_valid[0];
            if (point_valid[0]) begin
              x     <= xs[X_WIDTH-1:0];
              y     <= ys[Y_WIDTH-1:0];
              color <= erase ? BG_COLOR : colors[CW-1:0];
            end
          end
        end
        EMIT: begin
          if (adv) begin
            if (idx == LAST) begin
              state <= DONE;
              plot  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx  <= nidx;
              plot <= valid_snap[nidx];
              if (valid_snap[nidx]) begin
                x     <= xs_snap[nidx*X_WIDTH +: X_WIDTH];
                y     <= ys_snap[nidx*Y_WIDTH +: Y_WIDTH];
                color <= erase_snap ? BG_COLOR :
                         colors_snap[nidx*CW +: CW];
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/point_plotter.md
POINT_PLOTTER -- requirements
Module: point_plotter

Interface
REQ-001 Parameter NUM_POINTS, default 8, number of point slots scanned per frame (>=1).
REQ-002 Parameter X_WIDTH, default 8, x coordinate width.
REQ-003 Parameter Y_WIDTH, default 7, y coordinate width.
REQ-004 Parameter COLOR_DEPTH, default 1, bits per colour channel; colour word is 3*COLOR_DEPTH bits.
REQ-005 Parameter BG_COLOR, default 0, colour word emitted in erase mode.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 resetn  input  1  reset, synchronous, active-low.
REQ-008 start  input  1  request one scan of all slots; sampled only in IDLE.
REQ-009 erase  input  1  sampled with start; 1 = plot every valid point in BG_COLOR.
REQ-010 point_valid  input  NUM_POINTS  per-slot enable; bit i covers slot i.
REQ-011 xs  input  NUM_POINTS*X_WIDTH  packed x; slot i at bits [i*X_WIDTH +: X_WIDTH].
REQ-012 ys  input  NUM_POINTS*Y_WIDTH  packed y; same packing.
REQ-013 colors  input  NUM_POINTS*3*COLOR_DEPTH  packed per-slot colour; same packing.
REQ-014 plot_ready  input  1  downstream framebuffer writer accepts the current pixel.
REQ-015 x, y, color  output  X_WIDTH, Y_WIDTH, 3*COLOR_DEPTH  registered pixel.
REQ-016 plot  output  1  registered pixel-valid strobe.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at scan end.

Function
REQ-019 States: IDLE, EMIT, DONE; 
REQ-020 IDLE: on edge with start=1, snapshot point_valid, xs, ys, colors and erase; enter EMIT with idx=0 and present slot 0 at the same edge.
REQ-021 Presenting slot i: plot=point_valid_snap[i]; x, y = slot i coords; color = BG_COLOR if erase_snap else slot i colour.
REQ-022 Invalid slot: plot=0 for exactly one cycle, then advance unconditionally; x, y, color hold their previous values.
REQ-023 Valid slot: plot, x, y, color hold stable until an edge with plot_ready=1; that edge advances.
REQ-024 Advance from idx=NUM_POINTS-1 enters DONE with plot=0; DONE lasts one cycle with done=1, then IDLE.
REQ-025 Latency, all valid and plot_ready tied 1: start edge at cycle 0; plot high cycles 1..NUM_POINTS; done high cycle NUM_POINTS+1; busy high cycles 1..NUM_POINTS+1.
REQ-026 start and input changes while busy are ignored; scan uses only the snapshot.
REQ-027 start=1 in the DONE cycle is ignored; start held high re-triggers on the first IDLE edge.
REQ-028 point_valid all zero: scan still takes NUM_POINTS cycles with plot=0, then done.
REQ-029 idx counter width is clog2(NUM_POINTS), minimum 1; no wrap beyond NUM_POINTS-1.

Reset
REQ-030 On resetn=0 at an edge: state=IDLE, idx=0, plot=0, done=0, busy=0, x=0, y=0, color=0, snapshot cleared.
REQ-031 Reset mid-scan aborts immediately; no done pulse; next scan needs a new start.

Structure
REQ-032 Package point_plotter_pkg holds the state enum and the default X_WIDTH, Y_WIDTH and COLOR_DEPTH constants.
REQ-033 No sub-module; slot selection is an indexed part-select on the snapshot registers.

Verification
REQ-034 NUM_POINTS=8, all valid, plot_ready=1, slot i at (i, 2i), colour 3'b001 -> plot cycles 1-8 with coordinates in order; done on cycle 9.
REQ-035 point_valid=8'b1010_0101 -> plot high only for slots 0, 2, 5, 7; done still on cycle 9.
REQ-036 plot_ready low 3 cycles while slot 3 is presented -> x=3, y=6 held 4 cycles; done delayed to cycle 12.
REQ-037 erase=1 with start, BG_COLOR=0 -> every plotted pixel has color=0; coordinates unchanged.
REQ-038 resetn low at cycle 4 of a scan -> next cycle plot=0, busy=0; done never pulses; a later start scans from slot 0.
REQ-039 xs changed and start re-pulsed during a scan -> outputs follow the original snapshot; no second scan starts.
